// File: rtl/key_pkg.sv
// Shared state encoding and default 50 MHz timing for the key scan front end.
package key_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        DEB_DN  = 3'd1,
        PRESSED = 3'd2,
        REPEAT  = 3'd3,
        DEB_UP  = 3'd4
    } key_state_t;

    localparam int DEF_DEB_CYC  = 500_000;     // 10 ms
    localparam int DEF_HOLD_CYC = 25_000_000;  // 500 ms
    localparam int DEF_REP_CYC  = 10_000_000;  // 200 ms

    function automatic logic is_held(input key_state_t s);
        return (s == PRESSED) || (s == REPEAT) || (s == DEB_UP);
    endfunction

endpackage

// File: rtl/key_chan.sv
// One key channel: 2-FF synchroniser, debounce/auto-repeat FSM with one shared
// timer, and registered strobes that follow the FSM transitions.
module key_chan
    import key_pkg::*;
#(
    parameter int CNT_W    = 32,
    parameter int DEB_CYC  = DEF_DEB_CYC,
    parameter int HOLD_CYC = DEF_HOLD_CYC,
    parameter int REP_CYC  = DEF_REP_CYC,
    parameter bit REP_EN   = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key,
    output logic held,
    output logic press,
    output logic release_stb,
    output logic fire,
    output logic long_press
);

    localparam logic [CNT_W-1:0] DEB_LIM  = CNT_W'(DEB_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] REP_LIM  = CNT_W'(REP_CYC - 1);

    logic             sync_p0;
    logic             sync_p1;
    logic             ks;
    key_state_t       state;
    key_state_t       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             restart;
    logic             counting;
    logic             press_nxt;
    logic             release_nxt;
    logic             fire_nxt;

    // Stage p0/p1: synchroniser, preset to the released (high) level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_p0 <= 1'b1;
            sync_p1 <= 1'b1;
        end else begin
            sync_p0 <= key;
            sync_p1 <= sync_p0;
        end
    end

    assign ks = sync_p1;

    // Release is checked before any timer limit so a release always wins
    always_comb begin
        state_nxt   = state;
        restart     = 1'b0;
        press_nxt   = 1'b0;
        release_nxt = 1'b0;
        fire_nxt    = 1'b0;
        case (state)
            IDLE: begin
                if (!ks) state_nxt = DEB_DN;
            end
            DEB_DN: begin
                if (ks) begin
                    state_nxt = IDLE;
                end else if (cnt == DEB_LIM) begin
                    state_nxt = PRESSED;
                    press_nxt = 1'b1;
                    fire_nxt  = 1'b1;
                end
            end
            PRESSED: begin
                if (ks) begin
                    state_nxt = DEB_UP;
                end else if (REP_EN && (cnt == HOLD_LIM)) begin
                    state_nxt = REPEAT;
                    fire_nxt  = 1'b1;
                end
            end
            REPEAT: begin
                if (ks) begin
                    state_nxt = DEB_UP;
                end else if (cnt == REP_LIM) begin
                    restart  = 1'b1;
                    fire_nxt = 1'b1;
                end
            end
            DEB_UP: begin
                if (!ks) begin
                    state_nxt = PRESSED;
                end else if (cnt == DEB_LIM) begin
                    state_nxt   = IDLE;
                    release_nxt = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // IDLE and a non-repeating PRESSED never wait on the timer, so it holds there
    always_comb begin
        counting = (state == DEB_DN) || (state == DEB_UP) || (state == REPEAT) ||
                   ((state == PRESSED) && REP_EN);
        cnt_nxt  = cnt;
        if ((state_nxt != state) || restart) begin
            cnt_nxt = '0;
        end else if (counting) begin
            cnt_nxt = cnt + CNT_W'(1);
        end
    end

    // Stage p2: state, timer and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            held        <= 1'b0;
            press       <= 1'b0;
            release_stb <= 1'b0;
            fire        <= 1'b0;
            long_press  <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            held        <= is_held(state_nxt);
            press       <= press_nxt;
            release_stb <= release_nxt;
            fire        <= fire_nxt;
            long_press  <= (state_nxt == REPEAT);
        end
    end

endmodule

// File: rtl/key_scan_rep.sv
// N-channel push-button front end: independent debounce/auto-repeat per key.
// The release strobe is named release_stb because `release` is a reserved word.
module key_scan_rep
    import key_pkg::*;
#(
    parameter int NCH      = 4,
    parameter int CNT_W    = 32,
    parameter int DEB_CYC  = DEF_DEB_CYC,
    parameter int HOLD_CYC = DEF_HOLD_CYC,
    parameter int REP_CYC  = DEF_REP_CYC,
    parameter bit REP_EN   = 1'b1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [NCH-1:0] key,
    output logic [NCH-1:0] held,
    output logic [NCH-1:0] press,
    output logic [NCH-1:0] release_stb,
    output logic [NCH-1:0] fire,
    output logic [NCH-1:0] long_press
);

    for (genvar i = 0; i < NCH; i++) begin : g_chan
        key_chan #(
            .CNT_W   (CNT_W),
            .DEB_CYC (DEB_CYC),
            .HOLD_CYC(HOLD_CYC),
            .REP_CYC (REP_CYC),
            .REP_EN  (REP_EN)
        ) u_chan (
            .clk        (clk),
            .rst_n      (rst_n),
            .key        (key[i]),
            .held       (held[i]),
            .press      (press[i]),
            .release_stb(release_stb[i]),
            .fire       (fire[i]),
            .long_press (long_press[i])
        );
    end

endmodule

// File: tb/tb_key_scan_rep.sv
// Bench for key_scan_rep: two instances (repeat on/off) on shared keys, checked
// every cycle against a run-length model plus directed timing checks.
module tb_key_scan_rep;

    localparam int NCH  = 2;
    localparam int DEB  = 4;
    localparam int HOLD = 20;
    localparam int REP  = 8;

    logic           clk   = 1'b0;
    logic           rst_n = 1'b0;
    logic [NCH-1:0] key   = 2'b00;

    logic [NCH-1:0] held_a, press_a, rel_a, fire_a, lp_a;
    logic [NCH-1:0] held_b, press_b, rel_b, fire_b, lp_b;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    key_scan_rep #(.NCH(NCH), .CNT_W(8), .DEB_CYC(DEB), .HOLD_CYC(HOLD),
                   .REP_CYC(REP), .REP_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .key(key), .held(held_a), .press(press_a),
        .release_stb(rel_a), .fire(fire_a), .long_press(lp_a));

    key_scan_rep #(.NCH(NCH), .CNT_W(8), .DEB_CYC(DEB), .HOLD_CYC(HOLD),
                   .REP_CYC(REP), .REP_EN(1'b0)) dut_norep (
        .clk(clk), .rst_n(rst_n), .key(key), .held(held_b), .press(press_b),
        .release_stb(rel_b), .fire(fire_b), .long_press(lp_b));

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0d want=%0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Reference model: debouncing as run lengths of the (2-cycle delayed) key level.
    // q: zeros seen while released; o: ones seen while held; z: edges since the
    // current low run began (or since the press), -1 while high.
    logic [1:0] kd1, kd2;
    int         q[2][2], o[2][2], z[2][2];
    bit         hm[2][2];
    logic [1:0] e_held[2], e_press[2], e_rel[2], e_fire[2], e_lp[2];

    task automatic model_reset();
        kd1 = 2'b11;
        kd2 = 2'b11;
        for (int m = 0; m < 2; m++) begin
            e_held[m] = '0; e_press[m] = '0; e_rel[m] = '0; e_fire[m] = '0; e_lp[m] = '0;
            for (int c = 0; c < 2; c++) begin
                q[m][c] = 0; o[m][c] = 0; z[m][c] = -1; hm[m][c] = 1'b0;
            end
        end
    endtask

    task automatic model_step();
        logic [1:0] s;
        bit         ren;
        s   = kd2;
        kd2 = kd1;
        kd1 = key;
        for (int m = 0; m < 2; m++) begin
            ren = (m == 0);
            for (int c = 0; c < 2; c++) begin
                e_press[m][c] = 1'b0;
                e_rel[m][c]   = 1'b0;
                e_fire[m][c]  = 1'b0;
                if (!hm[m][c]) begin
                    if (!s[c]) begin
                        q[m][c]++;
                        if (q[m][c] == DEB + 1) begin
                            e_press[m][c] = 1'b1;
                            e_fire[m][c]  = 1'b1;
                            hm[m][c] = 1'b1; z[m][c] = 0; o[m][c] = 0; q[m][c] = 0;
                        end
                    end else begin
                        q[m][c] = 0;
                    end
                end else if (s[c]) begin
                    z[m][c] = -1;
                    o[m][c]++;
                    if (o[m][c] == DEB + 1) begin
                        e_rel[m][c] = 1'b1;
                        hm[m][c] = 1'b0; o[m][c] = 0; q[m][c] = 0;
                    end
                end else begin
                    o[m][c] = 0;
                    z[m][c]++;
                    if (ren && z[m][c] >= HOLD && ((z[m][c] - HOLD) % REP) == 0)
                        e_fire[m][c] = 1'b1;
                end
                e_held[m][c] = hm[m][c];
                e_lp[m][c]   = ren && hm[m][c] && (z[m][c] >= HOLD);
            end
        end
    endtask

    task automatic compare_all();
        chk("held_a",  held_a,  e_held[0]);
        chk("press_a", press_a, e_press[0]);
        chk("rel_a",   rel_a,   e_rel[0]);
        chk("fire_a",  fire_a,  e_fire[0]);
        chk("long_a",  lp_a,    e_lp[0]);
        chk("held_b",  held_b,  e_held[1]);
        chk("press_b", press_b, e_press[1]);
        chk("rel_b",   rel_b,   e_rel[1]);
        chk("fire_b",  fire_b,  e_fire[1]);
        chk("long_b",  lp_b,    e_lp[1]);
    endtask

    // Called at a negedge: drive key, let one active edge pass, check at next negedge
    task automatic run_cycle(input logic [1:0] k);
        key = k;
        @(posedge clk);
        if (!rst_n) model_reset();
        else        model_step();
        @(negedge clk);
        compare_all();
    endtask

    initial begin
        int first, cnt0, cnt1, lp_first, held_drop;
        int fires[$];
        int rels[$];
        int exp_fire[5];
        logic [1:0] pv_a, pv_b, rk;
        int dur[2];

        exp_fire = '{6, 26, 34, 42, 50};
        model_reset();
        @(negedge clk);

        // Reset held with keys low
        for (int i = 0; i < 4; i++) run_cycle(2'b00);
        chk("reset_outs", {held_a, press_a, rel_a, fire_a, lp_a,
                           held_b, press_b, rel_b, fire_b, lp_b}, 0);

        // Press latency after reset release
        rst_n = 1'b1;
        first = -1;
        for (int i = 0; i < 12; i++) begin
            run_cycle(2'b10);
            if (press_a[0] && first < 0) first = i;
        end
        chk("press_latency", first, 6);
        for (int i = 0; i < 14; i++) run_cycle(2'b11);

        // Glitch shorter than the debounce window
        cnt0 = 0;
        for (int i = 0; i < 15; i++) begin
            run_cycle(i < 3 ? 2'b10 : 2'b11);
            cnt0 += int'(press_a[0]) + int'(fire_a[0]) + int'(held_a[0]);
        end
        chk("glitch_quiet", cnt0, 0);

        // Auto-repeat on a long hold
        lp_first = -1;
        for (int i = 0; i < 56; i++) begin
            run_cycle(2'b10);
            if (fire_a[0]) fires.push_back(i);
            if (lp_a[0] && lp_first < 0) lp_first = i;
        end
        chk("repeat_count", fires.size(), 5);
        for (int i = 0; i < 5 && i < fires.size(); i++) chk("repeat_at", fires[i], exp_fire[i]);
        chk("long_start", lp_first, 26);

        // Bouncy release: high 2, low 1, then high for good from cycle 3
        held_drop = -1;
        for (int i = 0; i < 17; i++) begin
            run_cycle((i == 2) ? 2'b10 : 2'b11);
            if (rel_a[0]) rels.push_back(i);
            if (!held_a[0] && held_drop < 0) held_drop = i;
        end
        chk("bounce_rel_count", rels.size(), 1);
        if (rels.size() > 0) chk("bounce_rel_at", rels[0], 9);
        chk("bounce_held_drop", held_drop, 9);

        // Simultaneous press on both channels; no-repeat instance fires once
        cnt0 = 0; cnt1 = 0; pv_a = '0; pv_b = '0;
        for (int i = 0; i < 40; i++) begin
            run_cycle(2'b00);
            if (i == 6) begin pv_a = press_a; pv_b = press_b; end
            cnt0 += int'(fire_b[0]);
            cnt1 += int'(fire_b[1]);
        end
        chk("sim_press_a", pv_a, 2'b11);
        chk("sim_press_b", pv_b, 2'b11);
        chk("norep_fire0", cnt0, 1);
        chk("norep_fire1", cnt1, 1);
        for (int i = 0; i < 14; i++) run_cycle(2'b11);

        // Reset in the middle of a repeat hold
        for (int i = 0; i < 30; i++) run_cycle(2'b10);
        chk("long_before_rst", lp_a[0], 1'b1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_outs", {held_a, press_a, rel_a, fire_a, lp_a,
                               held_b, press_b, rel_b, fire_b, lp_b}, 0);
        model_reset();
        run_cycle(2'b10);
        rst_n = 1'b1;
        first = -1; cnt0 = 0;
        for (int i = 0; i < 12; i++) begin
            run_cycle(2'b10);
            if (press_a[0] && first < 0) first = i;
            cnt0 += int'(rel_a[0]) + int'(rel_b[0]);
        end
        chk("rst_repress_at", first, 6);
        chk("rst_no_release", cnt0, 0);
        for (int i = 0; i < 14; i++) run_cycle(2'b11);

        // Randomised holds, mostly longer than the debounce window
        rk  = 2'b11;
        dur = '{0, 0};
        for (int i = 0; i < 1500; i++) begin
            for (int c = 0; c < 2; c++) begin
                if (dur[c] == 0) begin
                    rk[c]  = 1'($urandom_range(0, 1));
                    dur[c] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4))
                                                          : int'($urandom_range(5, 40));
                end
                dur[c]--;
            end
            run_cycle(rk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
